// File: rtl/thunderbird_seq.sv
// -----------------------------------------------------------------------------
// thunderbird_seq
//
// Tail-light sequencer for LAMPS lamps per side. Everything runs from one
// clock: the step prescaler, the sequence step, the running-light PWM and the
// registered lamp drive. The sequence is left, right, hazard or idle. Brake and
// running lights are overlaid on top of it.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active-low
//   left     left turn request
//   right    right turn request
//   brk      brake
//   hzd      hazard request
//   rlight   running lights enable
//   display  registered lamp drives, 2*LAMPS bits
//              [2L-1:L] left side,  bit L   innermost
//              [L-1:0]  right side, bit L-1 innermost, bit 0 outermost
//   mode     current mode (00 idle, 01 left, 10 right, 11 hazard); this is
//            also the sequencer state register, brought out directly
// -----------------------------------------------------------------------------
module thunderbird_seq #(
    parameter int LAMPS      = 3,
    parameter int STEP_DIV   = 4,
    parameter int DIM_PERIOD = 4,
    parameter int DIM_DUTY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 left,
    input  logic                 right,
    input  logic                 brk,
    input  logic                 hzd,
    input  logic                 rlight,
    output logic [2*LAMPS-1:0]   display,
    output logic [1:0]           mode
);

    // Counter widths cover each counter's range, never narrower than 1 bit.
    localparam int STEP_W = $clog2(LAMPS + 1);
    localparam int PRE_W  = (STEP_DIV > 1)   ? $clog2(STEP_DIV)   : 1;
    localparam int PWM_W  = (DIM_PERIOD > 1) ? $clog2(DIM_PERIOD) : 1;
    localparam int DW     = 2 * LAMPS;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_W-1:0]  PWM_LAST  = PWM_W'(DIM_PERIOD - 1);
    localparam logic [31:0]       DUTY32    = DIM_DUTY;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_HAZARD = 2'b11
    } mode_t;

    mode_t              mode_q, mode_d, mode_req;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [PRE_W-1:0]   pre_q,  pre_d;
    logic [PWM_W-1:0]   pwm_q,  pwm_d;
    logic [DW-1:0]      display_q, display_d;

    logic               dim_on;
    logic [LAMPS-1:0]   turn_mask;   // index 0 = innermost lamp
    logic [LAMPS-1:0]   turn_rev;    // turn_mask mirrored for the right side
    logic [LAMPS-1:0]   left_lit, right_lit;

    assign mode    = mode_q;
    assign display = display_q;

    // Hazard takes priority, and pressing both turn requests together also
    // counts as hazard.
    always_comb begin
        mode_req = MODE_IDLE;
        if (hzd || (left && right)) mode_req = MODE_HAZARD;
        else if (left)              mode_req = MODE_LEFT;
        else if (right)             mode_req = MODE_RIGHT;
    end

    // The PWM counter is zero-extended into the comparison. With a duty of 0
    // the light is never on. With a duty of DIM_PERIOD or more it is always on.
    assign dim_on = (32'(pwm_q) < DUTY32);

    // Sequencer state: a mode change restarts the sequence at once. Otherwise
    // the prescaler gates each step advance.
    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        pre_d  = pre_q;
        pwm_d  = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;

        if (mode_req != mode_q) begin
            mode_d = mode_req;
            step_d = '0;
            pre_d  = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            case (mode_q)
                MODE_LEFT, MODE_RIGHT: step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
                MODE_HAZARD:           step_d = {{(STEP_W-1){1'b0}}, ~step_q[0]};
                default:               step_d = '0;
            endcase
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Lamp pattern from the pre-edge mode/step and the current inputs.
    always_comb begin
        turn_mask = '0;
        turn_rev  = '0;
        for (int i = 0; i < LAMPS; i++) begin
            turn_mask[i] = (32'(step_q) > 32'(i));
        end
        for (int i = 0; i < LAMPS; i++) begin
            turn_rev[LAMPS-1-i] = turn_mask[i];
        end

        left_lit  = {LAMPS{brk}};
        right_lit = {LAMPS{brk}};
        case (mode_q)
            MODE_LEFT:   left_lit  = turn_mask;
            MODE_RIGHT:  right_lit = turn_rev;
            // In hazard the step is only ever 0 or 1, so bit 0 is the phase.
            MODE_HAZARD: begin
                left_lit  = {LAMPS{brk | step_q[0]}};
                right_lit = {LAMPS{brk | step_q[0]}};
            end
            default: ;
        endcase

        // Lamps that are otherwise dark carry the running-light PWM.
        display_d = {left_lit, right_lit} | {DW{rlight & dim_on}};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q    <= MODE_IDLE;
            step_q    <= '0;
            pre_q     <= '0;
            pwm_q     <= '0;
            display_q <= '0;
        end else begin
            mode_q    <= mode_d;
            step_q    <= step_d;
            pre_q     <= pre_d;
            pwm_q     <= pwm_d;
            display_q <= display_d;
        end
    end

endmodule

// File: tb/tb_thunderbird_seq.sv
// -----------------------------------------------------------------------------
// tb_thunderbird_seq
//
// Directed and random stimulus for thunderbird_seq (LAMPS=3, STEP_DIV=4,
// DIM_PERIOD=4, DIM_DUTY=1). An integer reference model predicts mode and
// display for every edge into an expected queue. A few fixed lamp patterns are
// also checked as literals.
// -----------------------------------------------------------------------------
module tb_thunderbird_seq;

    localparam int L  = 3;
    localparam int SD = 4;
    localparam int DP = 4;
    localparam int DD = 1;
    localparam int DW = 2 * L;
    localparam int W  = DW + 2;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          rst, left, right, brk, hzd, rlight;
    logic [DW-1:0] display;
    logic [1:0]    mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    thunderbird_seq #(
        .LAMPS(L), .STEP_DIV(SD), .DIM_PERIOD(DP), .DIM_DUTY(DD)
    ) dut (
        .clk(clk), .rst(rst), .left(left), .right(right), .brk(brk),
        .hzd(hzd), .rlight(rlight), .display(display), .mode(mode)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode coding: 0 idle, 1 left, 2 right, 3 hazard.
    int m_mode = 0, m_step = 0, m_pre = 0, m_pwm = 0;

    function automatic logic [DW-1:0] pattern(input int md, input int st,
                                              input bit b, input bit rl, input bit dim);
        int full, turn, lh, rh;
        full = (1 << L) - 1;
        turn = (1 << st) - 1;           // st lamps counted from the inside
        lh   = b ? full : 0;
        rh   = b ? full : 0;
        if (md == 1) lh = turn;
        if (md == 2) rh = turn << (L - st);
        if (md == 3) begin
            lh = (b || st == 1) ? full : 0;
            rh = lh;
        end
        if (rl && dim) begin
            lh = full;
            rh = full;
        end
        return DW'((lh << L) | rh);
    endfunction

    task automatic model_edge(input bit r, input bit l, input bit rg,
                              input bit b, input bit h, input bit rl);
        logic [DW-1:0] d;
        int req;
        if (!r) begin
            m_mode = 0; m_step = 0; m_pre = 0; m_pwm = 0;
            d = '0;
        end else begin
            d   = pattern(m_mode, m_step, b, rl, m_pwm < DD);
            req = (h || (l && rg)) ? 3 : (l ? 1 : (rg ? 2 : 0));
            if (req != m_mode) begin
                m_mode = req; m_step = 0; m_pre = 0;
            end else if (m_pre == SD - 1) begin
                m_pre = 0;
                if (m_mode == 1 || m_mode == 2) m_step = (m_step + 1) % (L + 1);
                else if (m_mode == 3)           m_step = 1 - m_step;
                else                            m_step = 0;
            end else begin
                m_pre = m_pre + 1;
            end
            m_pwm = (m_pwm + 1) % DP;
        end
        exp_q.push_back({2'(m_mode), d});
    endtask

    // ---------------- driver ----------------
    // Drives one cycle's inputs, steps the model and checks after the edge.
    task automatic cyc(input bit r, input bit l, input bit rg,
                       input bit b, input bit h, input bit rl);
        logic [W-1:0] e;
        rst = r; left = l; right = rg; brk = b; hzd = h; rlight = rl;
        model_edge(r, l, rg, b, h, rl);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("display", {2'b0, display}, {2'b0, e[DW-1:0]});
        check("mode",    {6'b0, mode},    {6'b0, e[W-1:DW]});
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        bit found;
        bit r, l, rg, b, h, rl;
        rst = 1'b0; left = 1'b0; right = 1'b0; brk = 1'b0; hzd = 1'b0; rlight = 1'b0;

        // 1. reset, then idle
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check("reset_display", {2'b0, display}, 8'h00);
        check("reset_mode",    {6'b0, mode},    8'h00);
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0);
        check("idle_display", {2'b0, display}, 8'h00);

        // 2. left from idle
        for (int k = 1; k <= 21; k++) begin
            cyc(1, 1, 0, 0, 0, 0);
            if (k == 1)  check("left_mode", {6'b0, mode}, 8'h01);
            if (k == 6)  check("left_step1", {2'b0, display}, 8'b00_001000);
            if (k == 14) check("left_step3", {2'b0, display}, 8'b00_111000);
        end

        // 4. switch to right while the display shows 011000
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(1, 1, 0, 0, 0, 0);
            if (display == 6'b011000) found = 1'b1;
        end
        check("find_011000", {7'b0, found}, 8'h01);
        cyc(1, 0, 1, 0, 0, 0);
        check("switch_mode", {6'b0, mode}, 8'h02);
        cyc(1, 0, 1, 0, 0, 0);
        check("switch_display", {2'b0, display}, 8'h00);

        // 3. right with brake, then drop brake mid-step
        for (int k = 0; k < 22; k++) cyc(1, 0, 1, 1, 0, 0);
        for (int k = 0; k < 10; k++) cyc(1, 0, 1, 0, 0, 0);

        // 5. hazard variants
        for (int k = 0; k < 17; k++) cyc(1, 0, 0, 0, 1, 0);
        for (int k = 0; k < 17; k++) cyc(1, 1, 1, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc(1, 0, 0, 1, 1, 0);
            if (k == 6) check("hazard_brake", {2'b0, display}, 8'h3f);
        end

        // 6. running lights, reset mid-sequence
        for (int k = 0; k < 12; k++) cyc(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 22; k++) cyc(1, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 1);
        check("midreset_display", {2'b0, display}, 8'h00);
        check("midreset_mode",    {6'b0, mode},    8'h00);
        for (int k = 0; k < 10; k++) cyc(1, 1, 0, 0, 0, 1);

        // random phase: inputs held for a while so sequences can develop
        r = 1; l = 0; rg = 0; b = 0; h = 0; rl = 0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                l  = 1'($urandom_range(0, 1));
                rg = 1'($urandom_range(0, 1));
                h  = ($urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 7) == 0) b  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rl = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 99) != 0);
            cyc(r, l, rg, b, h, rl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
